// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate divider, scan counters and VGA sync generation.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync/video_on by PIPE_DEPTH clk.
module vga_sync_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

`ifdef VGA_SYNC_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif
  localparam int PIPE_N = PIPE_EN ? PIPE_DEPTH : 0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
  } sync_t;

  localparam sync_t SYNC_RST = sync_t'(3'b110);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic             x_last;
  logic             y_last;
  sync_t            sync_nxt;
  sync_t            sync_r;
  sync_t            sync_o;

  assign p_tick = (div_cnt == DIV_LAST);
  assign x_last = (pix_x == H_LAST);
  assign y_last = (pix_y == V_LAST);

  assign frame_tick = p_tick && x_last && y_last;

  always_comb begin
    x_nxt = pix_x;
    y_nxt = pix_y;
    if (p_tick) begin
      if (x_last) begin
        x_nxt = '0;
        y_nxt = y_last ? '0 : pix_y + 10'd1;
      end else begin
        x_nxt = pix_x + 10'd1;
      end
    end
  end

  // Sync levels follow the next-state counters so they land with pix_x/pix_y.
  always_comb begin
    sync_nxt          = SYNC_RST;
    sync_nxt.hsync    = !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
    sync_nxt.vsync    = !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));
    sync_nxt.video_on = (x_nxt < H_VIS) && (y_nxt < V_VIS);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
      sync_r  <= SYNC_RST;
    end else begin
      div_cnt <= p_tick ? '0 : div_cnt + DIV_W'(1);
      pix_x   <= x_nxt;
      pix_y   <= y_nxt;
      sync_r  <= sync_nxt;
    end
  end

  // Optional delay matching the overlay's font-ROM read latency.
  if (PIPE_N > 0) begin : g_pipe
    sync_t stage [PIPE_N];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < PIPE_N; i++) begin
          stage[i] <= SYNC_RST;
        end
      end else begin
        stage[0] <= sync_r;
        for (int i = 1; i < PIPE_N; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign sync_o = stage[PIPE_N-1];
  end else begin : g_direct
    assign sync_o = sync_r;
  end

  assign hsync    = sync_o.hsync;
  assign vsync    = sync_o.vsync;
  assign video_on = sync_o.video_on;

endmodule
